// File: rtl/ycbcr444_to_422.sv
// ycbcr444_to_422: packs pairs of 4:4:4 pixels into two 4:2:2 beats (Y0/Cb, then Y1/Cr).
// Define CHROMA_AVG_EN to average the pair's chroma instead of keeping P0's co-sited chroma.
module ycbcr444_to_422 #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_y,
   input  logic [WIDTH-1:0] in_cb,
   input  logic [WIDTH-1:0] in_cr,
   input  logic             in_eol,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_y,
   output logic [WIDTH-1:0] out_c,
   output logic             out_cflag,
   output logic             out_eol,
   output logic             out_valid,
   input  logic             out_ready
);

   typedef enum logic [1:0] {S_EVEN, S_ODD, S_OUT0, S_OUT1} state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic             w_in_xfer;
   logic             w_out_xfer;
   logic             w_pair_load;
   logic             w_hold_p0;
   logic [WIDTH-1:0] w_y0;
   logic [WIDTH-1:0] w_cb0;
   logic [WIDTH-1:0] w_cr0;
   logic [WIDTH-1:0] w_cb_pair;
   logic [WIDTH-1:0] w_cr_pair;

   logic [WIDTH-1:0] r_y0;
   logic [WIDTH-1:0] r_cb0;
   logic [WIDTH-1:0] r_cr0;
   logic [WIDTH-1:0] r_y1;
   logic [WIDTH-1:0] r_cr_pair;
   logic             r_pair_eol;
   logic [WIDTH-1:0] r_out_y;
   logic [WIDTH-1:0] r_out_c;
   logic             r_out_cflag;
   logic             r_out_eol;

`ifdef CHROMA_AVG_EN
   // Rounded mean at WIDTH+1 bits; the carry is kept so full-scale inputs cannot wrap.
   function automatic logic [WIDTH-1:0] f_avg(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
      logic [WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, 1'b1};
      return s[WIDTH:1];
   endfunction
`endif

   assign out_valid  = (r_state == S_OUT0) || (r_state == S_OUT1);
   assign w_in_xfer  = in_valid & in_ready;
   assign w_out_xfer = out_valid & out_ready;

   // A pair closes on P1 in S_ODD, or on an end-of-line P0 which then doubles as its own P1.
   assign w_pair_load = w_in_xfer & ((r_state == S_ODD) | in_eol);
   assign w_hold_p0   = w_in_xfer & (r_state != S_ODD) & ~in_eol;

   assign w_y0  = (r_state == S_ODD) ? r_y0  : in_y;
   assign w_cb0 = (r_state == S_ODD) ? r_cb0 : in_cb;
   assign w_cr0 = (r_state == S_ODD) ? r_cr0 : in_cr;

`ifdef CHROMA_AVG_EN
   assign w_cb_pair = f_avg(w_cb0, in_cb);
   assign w_cr_pair = f_avg(w_cr0, in_cr);
`else
   assign w_cb_pair = w_cb0;
   assign w_cr_pair = w_cr0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_EVEN;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      case (r_state)
         S_EVEN: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = in_eol ? S_OUT0 : S_ODD;
         end
         S_ODD: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = S_OUT0;
         end
         S_OUT0: begin
            if (out_ready) w_state_nxt = S_OUT1;
         end
         S_OUT1: begin
            in_ready = out_ready;
            if (out_ready) begin
               if (in_valid) w_state_nxt = in_eol ? S_OUT0 : S_ODD;
               else          w_state_nxt = S_EVEN;
            end
         end
         default: w_state_nxt = S_EVEN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_y0        <= '0;
         r_cb0       <= '0;
         r_cr0       <= '0;
         r_y1        <= '0;
         r_cr_pair   <= '0;
         r_pair_eol  <= 1'b0;
         r_out_y     <= '0;
         r_out_c     <= '0;
         r_out_cflag <= 1'b0;
         r_out_eol   <= 1'b0;
      end else begin
         if (w_hold_p0) begin
            r_y0  <= in_y;
            r_cb0 <= in_cb;
            r_cr0 <= in_cr;
         end
         // Loading a new pair wins over advancing to beat 1 (S_OUT1 back-to-back case).
         if (w_pair_load) begin
            r_y1        <= in_y;
            r_cr_pair   <= w_cr_pair;
            r_pair_eol  <= in_eol;
            r_out_y     <= w_y0;
            r_out_c     <= w_cb_pair;
            r_out_cflag <= 1'b0;
            r_out_eol   <= 1'b0;
         end else if (w_out_xfer && (r_state == S_OUT0)) begin
            r_out_y     <= r_y1;
            r_out_c     <= r_cr_pair;
            r_out_cflag <= 1'b1;
            r_out_eol   <= r_pair_eol;
         end
      end
   end

   assign out_y     = r_out_y;
   assign out_c     = r_out_c;
   assign out_cflag = r_out_cflag;
   assign out_eol   = r_out_eol;

endmodule

// File: tb/tb_ycbcr444_to_422.sv
// Directed bench for ycbcr444_to_422; expected chroma follows CHROMA_AVG_EN when defined.
module tb_ycbcr444_to_422;

   localparam int W = 10;
`ifdef CHROMA_AVG_EN
   localparam bit AVG = 1'b1;
`else
   localparam bit AVG = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] in_y, in_cb, in_cr;
   logic         in_eol, in_valid, in_ready;
   logic [W-1:0] out_y, out_c;
   logic         out_cflag, out_eol, out_valid, out_ready;

   int checks = 0;
   int errors = 0;
   int pi, bi, cyc, k;

   ycbcr444_to_422 #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .in_y(in_y), .in_cb(in_cb), .in_cr(in_cr),
      .in_eol(in_eol), .in_valid(in_valid), .in_ready(in_ready),
      .out_y(out_y), .out_c(out_c), .out_cflag(out_cflag),
      .out_eol(out_eol), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_beat(input string tag, input int y, input int c, input int cf, input int eol);
      chk({tag, ".valid"}, 32'(out_valid), 1);
      chk({tag, ".y"},     32'(out_y), y);
      chk({tag, ".c"},     32'(out_c), c);
      chk({tag, ".cflag"}, 32'(out_cflag), cf);
      chk({tag, ".eol"},   32'(out_eol), eol);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input int y, input int cb, input int cr, input logic eol);
      in_valid = v;
      in_y     = W'(y);
      in_cb    = W'(cb);
      in_cr    = W'(cr);
      in_eol   = eol;
   endtask

   initial begin
      rst = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, 0, 0, 0, 1'b0);
      step();
      step();
      chk("rst.out_valid", 32'(out_valid), 0);
      chk("rst.out_y", 32'(out_y), 0);
      chk("rst.out_c", 32'(out_c), 0);
      chk("rst.out_cflag", 32'(out_cflag), 0);
      chk("rst.out_eol", 32'(out_eol), 0);
      chk("rst.in_ready", 32'(in_ready), 1);
      rst = 1'b1;
      step();

      // Basic pair, with idle cycles while P0 is held
      drive(1'b1, 100, 200, 300, 1'b0);
      #1 chk("p0.in_ready", 32'(in_ready), 1);
      step();
      drive(1'b0, 999, 999, 999, 1'b1);
      step();
      chk("odd_hold.out_valid", 32'(out_valid), 0);
      chk("odd_hold.in_ready", 32'(in_ready), 1);
      step();
      chk("odd_hold2.out_valid", 32'(out_valid), 0);
      drive(1'b1, 110, 201, 303, 1'b0);
      step();
      drive(1'b0, 0, 0, 0, 1'b0);
      #1 chk("b0.in_ready", 32'(in_ready), 0);
      chk_beat("basic.b0", 100, AVG ? 201 : 200, 0, 0);
      step();
      chk_beat("basic.b1", 110, AVG ? 302 : 300, 1, 0);
      step();
      chk("basic.idle", 32'(out_valid), 0);

      // Full-scale values must not wrap
      drive(1'b1, 1023, 1023, 1023, 1'b0);
      step();
      drive(1'b1, 1023, 1023, 1023, 1'b0);
      step();
      drive(1'b0, 0, 0, 0, 1'b0);
      chk_beat("max.b0", 1023, 1023, 0, 0);
      step();
      chk_beat("max.b1", 1023, 1023, 1, 0);
      step();

      // Orphan pixel at end of line
      drive(1'b1, 50, 60, 70, 1'b1);
      step();
      drive(1'b0, 0, 0, 0, 1'b0);
      chk_beat("orphan.b0", 50, 60, 0, 0);
      step();
      chk_beat("orphan.b1", 50, 70, 1, 1);
      step();
      chk("orphan.idle", 32'(out_valid), 0);

      // Back-pressure in S_OUT0 and S_OUT1; offered input must be ignored
      drive(1'b1, 1, 2, 3, 1'b0);
      step();
      drive(1'b1, 5, 6, 7, 1'b1);
      step();
      out_ready = 1'b0;
      drive(1'b1, 999, 999, 999, 1'b1);
      for (int i = 0; i < 5; i++) begin
         #1 chk("stall0.in_ready", 32'(in_ready), 0);
         chk_beat("stall0", 1, AVG ? 4 : 2, 0, 0);
         step();
      end
      out_ready = 1'b1;
      drive(1'b0, 0, 0, 0, 1'b0);
      #1 chk_beat("release.b0", 1, AVG ? 4 : 2, 0, 0);
      step();
      out_ready = 1'b0;
      drive(1'b1, 888, 888, 888, 1'b0);
      #1 chk("stall1.in_ready", 32'(in_ready), 0);
      chk_beat("stall1", 5, AVG ? 5 : 3, 1, 1);
      step();
      chk_beat("stall1.held", 5, AVG ? 5 : 3, 1, 1);
      out_ready = 1'b1;
      drive(1'b0, 0, 0, 0, 1'b0);
      step();
      chk("release.idle", 32'(out_valid), 0);

      // Continuous stream of 64 pixels
      pi = 0;
      bi = 0;
      cyc = 0;
      while (bi < 64 && cyc < 300) begin
         drive(pi < 64, pi + 10, 2 * pi, 2 * pi + 1, (pi % 8) == 7);
         #1;
         if (out_valid) begin
            k = bi / 2;
            if ((bi % 2) == 0)
               chk_beat("stream.b0", 2 * k + 10, AVG ? 4 * k + 1 : 4 * k, 0, 0);
            else
               chk_beat("stream.b1", 2 * k + 11, AVG ? 4 * k + 2 : 4 * k + 1, 1, (k % 4) == 3);
            bi++;
         end
         if (in_valid && in_ready) pi++;
         cyc++;
         @(posedge clk);
         #1;
      end
      drive(1'b0, 0, 0, 0, 1'b0);
      chk("stream.beats", 32'(bi), 64);
      chk("stream.pixels", 32'(pi), 64);
      chk("stream.cycles", 32'(cyc), 97);
      step();
      chk("stream.idle", 32'(out_valid), 0);

      // Reset while P0 is held in S_ODD
      drive(1'b1, 7, 8, 9, 1'b0);
      step();
      rst = 1'b0;
      drive(1'b0, 0, 0, 0, 1'b0);
      step();
      rst = 1'b1;
      #1 chk("midrst.out_valid", 32'(out_valid), 0);
      chk("midrst.in_ready", 32'(in_ready), 1);
      chk("midrst.out_y", 32'(out_y), 0);
      drive(1'b1, 20, 40, 60, 1'b0);
      step();
      chk("midrst.odd_valid", 32'(out_valid), 0);
      drive(1'b1, 22, 42, 62, 1'b1);
      step();
      drive(1'b0, 0, 0, 0, 1'b0);
      chk_beat("midrst.b0", 20, AVG ? 41 : 40, 0, 0);
      step();
      chk_beat("midrst.b1", 22, AVG ? 61 : 60, 1, 1);
      step();
      chk("midrst.idle", 32'(out_valid), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
